// File: rtl/blink_pkg.sv
// blink_pkg: shared state encoding, defaults and parameter checks for blink_stretcher
package blink_pkg;

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    localparam int PEND_W_DEFAULT = 4;

    // Largest backlog a PEND_W-bit pending counter can hold.
    function automatic int pend_max(input int w);
        return (1 << w) - 1;
    endfunction

    // True when a phase length fits the phase timer and is at least one cycle.
    function automatic bit cycles_ok(input int cycles, input int cnt_w);
        return cycles >= 1 && longint'(cycles) < (longint'(1) << cnt_w);
    endfunction

endpackage

// File: rtl/blink_timer.sv
// blink_timer: loadable down-counter with terminal-count flag, shared by ON and GAP phases
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this edge (wins over counting)
//   load_val   : value loaded into the counter
//   done       : counter is zero; counting stops there, so it never underflows
module blink_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (!done) cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/blink_stretcher.sv
// blink_stretcher: stretches single-cycle events into visible LED blinks with a saturating replay queue
//   clk, rst_n : clock, async active-low reset
//   event_in   : event strobe, one event per high cycle
//   led        : LED drive, high only in the ON phase
//   busy       : high in ON and GAP
//   pending    : queued events not yet blinked
//   overflow   : one-cycle pulse after an event was dropped on a full queue
module blink_stretcher
    import blink_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int ON_CYCLES  = 500000,
    parameter int GAP_CYCLES = 500000,
    parameter int PEND_W     = PEND_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              event_in,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    if (!cycles_ok(ON_CYCLES, CNT_W) || !cycles_ok(GAP_CYCLES, CNT_W)) begin : g_bad_cycles
        $error("blink_stretcher: ON_CYCLES and GAP_CYCLES must lie in [1, 2^CNT_W-1]");
    end

    localparam logic [CNT_W-1:0]  ON_VAL  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_VAL = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] P_MAX   = PEND_W'(pend_max(PEND_W));

    state_t            state, next_state;
    logic              tmr_load, tmr_done, start_direct, dec, inc, drop;
    logic [CNT_W-1:0]  tmr_val;
    logic [PEND_W-1:0] pending_next;

    blink_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        next_state   = state;
        tmr_load     = 1'b0;
        tmr_val      = ON_VAL;
        start_direct = 1'b0;
        dec          = 1'b0;
        case (state)
            IDLE: begin
                next_state   = event_in ? ON : IDLE;
                tmr_load     = event_in;
                start_direct = event_in;
            end
            ON: begin
                next_state = tmr_done ? GAP : ON;
                tmr_load   = tmr_done;
                tmr_val    = GAP_VAL;
            end
            GAP: if (tmr_done) begin
                // A queued event takes priority; a fresh event is consumed directly only on an empty queue.
                next_state   = (pending != '0 || event_in) ? ON : IDLE;
                tmr_load     = pending != '0 || event_in;
                dec          = pending != '0;
                start_direct = event_in && pending == '0;
            end
            default: next_state = IDLE;
        endcase
        inc          = event_in && !start_direct;
        drop         = inc && !dec && pending == P_MAX;
        pending_next = (inc && !dec && !drop) ? pending + 1'b1 :
                       (dec && !inc)          ? pending - 1'b1 : pending;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= next_state;
            pending  <= pending_next;
            overflow <= drop;
        end
    end

    assign led  = (state == ON);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_blink_stretcher.sv
// tb_blink_stretcher: directed checks of blink timing, queueing, saturation and async reset
module tb_blink_stretcher;

    localparam int NCYC = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       event_in = 1'b0;
    logic       led, busy, overflow;
    logic [1:0] pending;

    int total = 0;
    int bad = 0;

    blink_stretcher #(
        .CNT_W      (4),
        .ON_CYCLES  (4),
        .GAP_CYCLES (3),
        .PEND_W     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .event_in (event_in),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bitm(input int n);
        logic [63:0] m = '0;
        m[n] = 1'b1;
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle c is the interval after edge c-1; inputs set in cycle c are sampled at edge c.
    task automatic run(input string name, input logic [63:0] ev, input logic [63:0] rst,
                       input logic [63:0] exp_led, input logic [63:0] exp_busy,
                       input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] exp_ov);
        rst_n    = 1'b0;
        event_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < NCYC; c++) begin
            #1;
            event_in = ev[c];
            rst_n    = !rst[c];
            #1;
            check($sformatf("%s led c%0d", name, c), 32'(led), 32'(exp_led[c]));
            check($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(exp_busy[c]));
            check($sformatf("%s pending c%0d", name, c), 32'(pending), 32'({p1[c], p0[c]}));
            check($sformatf("%s overflow c%0d", name, c), 32'(overflow), 32'(exp_ov[c]));
            @(posedge clk);
        end
        event_in = 1'b0;
    endtask

    initial begin
        #2;
        check("reset led", 32'(led), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset pending", 32'(pending), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);

        run("single", bitm(10), '0, rng(11, 14), rng(11, 17), '0, '0, '0);

        run("b2b", rng(10, 12), '0,
            rng(11, 14) | rng(18, 21) | rng(25, 28), rng(11, 31),
            bitm(12) | rng(18, 24), rng(13, 17), '0);

        run("sat", rng(10, 14), '0,
            rng(11, 14) | rng(18, 21) | rng(25, 28) | rng(32, 35), rng(11, 38),
            bitm(12) | rng(14, 17) | rng(25, 31), rng(13, 24), bitm(15));

        run("chain", bitm(10) | bitm(17), '0,
            rng(11, 14) | rng(18, 21), rng(11, 24), '0, '0, '0);

        run("coinc", bitm(10) | bitm(11) | bitm(17), '0,
            rng(11, 14) | rng(18, 21) | rng(25, 28), rng(11, 31),
            rng(12, 24), '0, '0);

        run("rst", bitm(10) | bitm(11) | bitm(20), bitm(13),
            rng(11, 12) | rng(21, 24), rng(11, 12) | rng(21, 27),
            bitm(12), '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
